// File: rtl/dmem_mmio_if.sv
// Processor data port plus TX byte-stream handshake for dmem_mmio.
// master: processor/consumer side; slave: the memory system.
interface dmem_mmio_if;
    logic        WE;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output WE, address_to_mem, data_to_mem, tx_ready,
        input  data_from_mem, tx_valid, tx_data
    );

    modport slave (
        input  WE, address_to_mem, data_to_mem, tx_ready,
        output data_from_mem, tx_valid, tx_data
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data-side memory for a single-cycle core: word RAM with combinational
// read, plus an MMIO page holding a TX byte FIFO, a status register and a
// free-running cycle counter. Writes commit on the rising edge.
module dmem_mmio #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input logic        clk,
    input logic        reset,
    dmem_mmio_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // MMIO word addresses (byte address >> 2)
    localparam logic [29:0] TX_DATA_WA = 30'h3FFF_FFC0;
    localparam logic [29:0] STATUS_WA  = 30'h3FFF_FFC1;
    localparam logic [29:0] CYCLE_WA   = 30'h3FFF_FFC2;

    logic [31:0]       ram [2**ADDR_W];
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [31:0]       cycle_cnt;

    logic [29:0]       word_addr;
    logic [ADDR_W-1:0] ram_idx;
    logic              in_ram;
    logic              sel_tx;
    logic              sel_status;
    logic              sel_cycle;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push_req;
    logic              push_ok;
    logic              push_drop;
    logic              unused_addr_lsb;
    logic [31:0]       status_val;

    assign word_addr       = bus.address_to_mem[31:2];
    assign ram_idx         = bus.address_to_mem[ADDR_W+1:2];
    assign in_ram          = (bus.address_to_mem[31:ADDR_W+2] == '0);
    assign sel_tx          = (word_addr == TX_DATA_WA);
    assign sel_status      = (word_addr == STATUS_WA);
    assign sel_cycle       = (word_addr == CYCLE_WA);
    assign unused_addr_lsb = ^bus.address_to_mem[1:0];

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign pop       = !empty && bus.tx_ready;
    assign push_req  = bus.WE && sel_tx;
    // A pop in the same cycle frees the slot the push needs, so full alone
    // does not drop the byte.
    assign push_ok   = push_req && (!full || pop);
    assign push_drop = push_req && full && !pop;

    // Head comes straight from registered storage, never from tx_ready.
    assign bus.tx_valid = !empty;
    assign bus.tx_data  = fifo_mem[rd_ptr];

    // RAM write port; reset blocks stores in the reset cycle.
    always_ff @(posedge clk) begin
        if (!reset && bus.WE && in_ram) begin
            ram[ram_idx] <= bus.data_to_mem;
        end
    end

    // TX FIFO pointers, occupancy, storage and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= 8'h00;
            end
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= bus.data_to_mem[7:0];
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A new overflow wins over a same-cycle clear.
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (bus.WE && sel_status) begin
                overflow <= 1'b0;
            end
        end
    end

    // Free-running cycle counter, loadable by a CYCLE write.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (bus.WE && sel_cycle) begin
            cycle_cnt <= bus.data_to_mem;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_val            = '0;
        status_val[CW-1:0]    = count;
        status_val[16]        = full;
        status_val[17]        = empty;
        status_val[24]        = overflow;
    end

    // Combinational load mux; unmapped addresses and TX_DATA read as 0.
    always_comb begin
        bus.data_from_mem = 32'h0;
        if (in_ram) begin
            bus.data_from_mem = ram[ram_idx];
        end else if (sel_status) begin
            bus.data_from_mem = status_val;
        end else if (sel_cycle) begin
            bus.data_from_mem = cycle_cnt;
        end
    end
endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory system sitting directly downstream of the single-cycle processor's data port: it consumes `WE`, `address_to_mem` and `data_to_mem` and produces `data_from_mem` in the same cycle. It provides word-addressed data RAM and a small MMIO page. The MMIO page holds a byte-stream transmit FIFO with a valid/ready output, a status register and a free-running cycle counter. Reads are combinational and writes are committed on the clock edge, which matches the processor's single-cycle load/store timing.

## Interface
- `ADDR_W`, 8: RAM word-address width (RAM holds 2^ADDR_W 32-bit words).
- `FIFO_DEPTH`, 8: TX FIFO entries, power of two, ≥2.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `WE` input 1: write enable from processor.
- `address_to_mem` input 32: byte address (low 2 bits ignored).
- `data_to_mem` input 32: store data.
- `data_from_mem` output 32: load data, combinational from current state.
- `tx_valid` output 1: FIFO head valid (FIFO not empty).
- `tx_data` output 8: FIFO head byte.
- `tx_ready` input 1: consumer accepts head this cycle.

## Operation
- Address decode:
  - RAM region: `address_to_mem[31:ADDR_W+2] == 0`; word index `address_to_mem[ADDR_W+1:2]`.
  - TX_DATA at 0xFFFF_FF00.
  - STATUS at 0xFFFF_FF04.
  - CYCLE at 0xFFFF_FF08.
  - Any other address: reads return 0, writes are ignored.
- RAM:
  - Asynchronous read.
  - Write on the edge when `WE`=1 and the address is in the region.
  - Contents are not affected by reset; they are undefined until written.
- TX_DATA:
  - A write pushes `data_to_mem[7:0]`.
  - A read returns 0.
- TX FIFO:
  - Circular buffer with read and write pointers and a count of width log2(FIFO_DEPTH)+1.
  - Pop when `tx_valid && tx_ready`.
  - Push when a TX_DATA write occurs and (count < FIFO_DEPTH or a pop happens in the same cycle).
  - A push while full with no simultaneous pop is dropped and sets the sticky `overflow` flag.
  - Simultaneous push and pop when empty: no pop occurs (`tx_valid`=0); the push is accepted and count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
- STATUS read value:
  - [15:0] count, zero-extended.
  - [16] full.
  - [17] empty.
  - [24] overflow.
  - All other bits 0.
  - Any write to STATUS clears `overflow`. If an overflow occurs in the same cycle as the clear, the flag ends set.
- CYCLE:
  - 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF→0.
  - A write loads `data_to_mem` exactly (no +1 that cycle).
  - A read returns the current value.
- `data_from_mem` is valid for every address regardless of `WE`. A read of a location written in the same cycle returns the old value.

## Timing
- Reset values:
  - count=0, pointers=0, overflow=0, CYCLE=0.
  - `tx_valid`=0.
  - `tx_data`=RAM-undefined byte is not allowed: FIFO storage output is 0 after reset until the first push.
  - `data_from_mem` reflects the reset state (STATUS reads 0x0002_0000).
- Reset dominates: a `WE` or pop in the reset cycle has no effect. Reset asserted mid-stream empties the FIFO; queued bytes are lost.
- Write latency: the stored value is visible to reads in the cycle after the `WE` edge.
- FIFO latency: a byte pushed at edge N gives `tx_valid`=1 from cycle N+1 (when previously empty).
- `tx_data`/`tx_valid` depend only on registered state, never combinationally on `tx_ready`.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- RAM: write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 next cycle → 0xDEADBEEF. Read 0x0000_0013 → same word. Read 0x0000_0400 (out of region, ADDR_W=8) → 0.
- FIFO order: `tx_ready`=0, push 0x41,0x42,0x43 → STATUS=0x0000_0003. Then `tx_ready`=1 → `tx_data` 0x41,0x42,0x43 on consecutive cycles, then `tx_valid`=0 and STATUS=0x0002_0000.
- Overflow: push 9 bytes with `tx_ready`=0 → STATUS=0x0101_0008 and the 9th byte is absent on drain. Write STATUS → bit 24 cleared next cycle.
- Full plus simultaneous push/pop: FIFO full, `tx_ready`=1 and a push of 0x55 in the same cycle → count stays 8, overflow stays 0, and 0x55 drains last.
- CYCLE: after reset read CYCLE at cycle k → k. Write 0xFFFF_FFFE → reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on the next three cycles.
- Reset mid-operation: 5 bytes queued, CYCLE=100, assert `reset` for one cycle → `tx_valid`=0, STATUS=0x0002_0000, CYCLE=0. RAM contents written before reset are unchanged.
